// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 correction applied before each doubling step.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  // Digits of 5 or more would exceed 9 after doubling, so pre-bias them by 3.
  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_ADJ_THRESH) begin
      d_o = d_i + BCD_ADJ_ADD;
    end else begin
      d_o = d_i;
    end
  end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Multi-cycle double-dabble converter: one operand bit per clock, valid/ready on both sides.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_binary,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  bcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] adj_s;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .d_o (adj_s[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bin_q   <= {WIDTH{1'b0}};
      bcd_q   <= {BCD_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; the counter hitting zero costs one extra
  // cycle in SHIFT, which is the DONE-entry cycle of the fixed latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(WIDTH);
          bin_d   = in_binary;
          bcd_d   = {BCD_W{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          // A bit carried out of the top digit is a lost multiple of 10^DIGITS.
          ovf_d = ovf_q | adj_s[BCD_W-1];
          bcd_d = {adj_s[BCD_W-2:0], bin_q[WIDTH-1]};
          bin_d = {bin_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bcd      = bcd_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench: 3-digit and 2-digit converters share one input stream.
module tb_bcd_convert_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_binary;
  logic        out_ready;
  logic        in_ready,  out_valid,  out_overflow;
  logic [11:0] out_bcd;
  logic        in_ready2, out_valid2, out_overflow2;
  logic [7:0]  out_bcd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_convert_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_binary(in_binary), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_overflow(out_overflow)
  );

  bcd_convert_ctrl #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_binary(in_binary), .out_valid(out_valid2), .out_ready(out_ready),
    .out_bcd(out_bcd2), .out_overflow(out_overflow2)
  );

  function automatic logic [11:0] ref_bcd3(input int v);
    ref_bcd3 = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] ref_bcd2(input int v);
    ref_bcd2 = {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drives one operand through both DUTs and returns what each produced.
  task automatic do_convert(input logic [7:0] v,
                            output logic [11:0] b3, output logic o3,
                            output logic [7:0] b2, output logic o2,
                            output int cycles, output bit timeout);
    @(negedge clk);
    in_binary = v;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk);
      #1 cycles++;
    end while (!out_valid && cycles < 50);
    timeout = (cycles >= 50);
    b3 = out_bcd;  o3 = out_overflow;
    b2 = out_bcd2; o2 = out_overflow2;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_binary = 8'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 12'h000 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b bcd=%h ovf=%b, required 1 0 000 0",
               in_ready, out_valid, out_bcd, out_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [11:0] b3; logic o3; logic [7:0] b2; logic o2; int cyc; bit to;
    do_convert(8'd0, b3, o3, b2, o2, cyc, to);
    checks++;
    if (to || cyc !== 9) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, required 9", cyc);
    end
    checks++;
    if (b3 !== 12'h000 || o3 !== 1'b0) begin
      errors++;
      $display("FAIL zero_value: got %h ovf=%b, required 000 ovf=0", b3, o3);
    end
  endtask

  task automatic test_values();
    logic [7:0]  vals [3] = '{8'd255, 8'd99, 8'd100};
    logic [11:0] exp3 [3] = '{12'h255, 12'h099, 12'h100};
    logic [11:0] b3; logic o3; logic [7:0] b2; logic o2; int cyc; bit to;
    for (int i = 0; i < 3; i++) begin
      do_convert(vals[i], b3, o3, b2, o2, cyc, to);
      checks++;
      if (to || b3 !== exp3[i] || o3 !== 1'b0) begin
        errors++;
        $display("FAIL value_%0d: got %h ovf=%b timeout=%b, required %h ovf=0",
                 vals[i], b3, o3, to, exp3[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4] = '{8'd100, 8'd199, 8'd99, 8'd255};
    logic [7:0] expb [4] = '{8'h00, 8'h99, 8'h99, 8'h55};
    logic       expo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] b3; logic o3; logic [7:0] b2; logic o2; int cyc; bit to;
    for (int i = 0; i < 4; i++) begin
      do_convert(vals[i], b3, o3, b2, o2, cyc, to);
      checks++;
      if (to || b2 !== expb[i] || o2 !== expo[i]) begin
        errors++;
        $display("FAIL overflow2_%0d: got %h ovf=%b, required %h ovf=%b",
                 vals[i], b2, o2, expb[i], expo[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ready_seen;
    @(negedge clk);
    in_binary = 8'd77; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    ready_seen = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      in_valid  = cyc[0];
      in_binary = 8'd200;
      if (in_ready) ready_seen = 1'b1;
      cyc++;
    end while (!out_valid && cyc < 50);
    checks++;
    if (ready_seen || cyc >= 50) begin
      errors++;
      $display("FAIL bp_shift: in_ready_seen=%b cycles=%0d, required 0 and <50", ready_seen, cyc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      checks++;
      if (out_valid !== 1'b1 || out_bcd !== 12'h077 || out_overflow !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b bcd=%h in_ready=%b, required 1 077 0",
                 i, out_valid, out_bcd, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    in_binary = 8'd42; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_binary = 8'd7;
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!out_valid && cyc < 50);
    checks++;
    if (cyc !== 9 || out_bcd !== 12'h042) begin
      errors++;
      $display("FAIL b2b_first: got %h after %0d cycles, required 042 after 9", out_bcd, cyc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: in_ready=%b, required 0", in_ready);
    end
    in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!out_valid && cyc < 50);
    checks++;
    if (cyc !== 9 || out_bcd !== 12'h007) begin
      errors++;
      $display("FAIL b2b_second: got %h after %0d cycles, required 007 after 9", out_bcd, cyc);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] b3; logic o3; logic [7:0] b2; logic o2; int cyc; bit to;
    @(negedge clk);
    in_binary = 8'd200; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b bcd=%h, required 0 1 000",
               out_valid, in_ready, out_bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_convert(8'd128, b3, o3, b2, o2, cyc, to);
    checks++;
    if (to || b3 !== 12'h128 || o3 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got %h ovf=%b, required 128 ovf=0", b3, o3);
    end
  endtask

  task automatic test_sweep();
    logic [11:0] b3; logic o3; logic [7:0] b2; logic o2; int cyc; bit to;
    for (int v = 0; v < 256; v++) begin
      do_convert(8'(v), b3, o3, b2, o2, cyc, to);
      checks++;
      if (to || cyc !== 9 || b3 !== ref_bcd3(v) || o3 !== 1'b0) begin
        errors++;
        $display("FAIL sweep3_%0d: got %h ovf=%b cyc=%0d, required %h ovf=0 cyc=9",
                 v, b3, o3, cyc, ref_bcd3(v));
      end
      checks++;
      if (b2 !== ref_bcd2(v) || o2 !== (v >= 100)) begin
        errors++;
        $display("FAIL sweep2_%0d: got %h ovf=%b, required %h ovf=%b",
                 v, b2, o2, ref_bcd2(v), (v >= 100));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
